// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing generator. A clock divider produces the
// pixel enable, free-running h/v counters walk the raster, and a one-pixel
// output register drives colour and active-low syncs to the DAC pins while
// pixels are pulled from an upstream valid/ready source in the active area.
module vga_timing_gen #(
  parameter int CLK_DIV = 2,
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int COLOR_W = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_valid,
  input  logic [COLOR_W-1:0] pix_data,
  output logic               pix_ready,
  output logic [9:0]         pix_x,
  output logic [9:0]         pix_y,
  output logic               frame_start,
  output logic               line_start,
  output logic               underflow,
  input  logic               underflow_clr,
  output logic [COLOR_W-1:0] vga_color,
  output logic               vga_hs,
  output logic               vga_vs
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
  localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
  localparam logic [9:0] H_VIS_C  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_C  = 10'(V_VIS);
  localparam logic [9:0] HS_BEG   = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG   = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);
  localparam logic [COLOR_W-1:0] BLACK = {COLOR_W{1'b0}};

  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [9:0]         h_cnt_q, h_cnt_d;
  logic [9:0]         v_cnt_q, v_cnt_d;
  logic [COLOR_W-1:0] color_q, color_d;
  logic               hs_q, hs_d;
  logic               vs_q, vs_d;
  logic               uf_q, uf_d;

  logic pix_en_s;
  logic active_s;
  logic hs_n_s;
  logic vs_n_s;
  logic h_wrap_s;

  // Pixel strobe and decode of the current raster position
  always_comb begin
    pix_en_s = (div_cnt_q == DIV_LAST) && !rst;
    active_s = (h_cnt_q < H_VIS_C) && (v_cnt_q < V_VIS_C);
    hs_n_s   = !((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
    vs_n_s   = !((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));
    h_wrap_s = (h_cnt_q == H_LAST);
  end

  // Next state of the divider and raster counters
  always_comb begin
    div_cnt_d = (div_cnt_q == DIV_LAST) ? DIV_ZERO : (div_cnt_q + DIV_ONE);
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    if (pix_en_s) begin
      h_cnt_d = h_wrap_s ? 10'd0 : (h_cnt_q + 10'd1);
      if (h_wrap_s) begin
        v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : (v_cnt_q + 10'd1);
      end else begin
        v_cnt_d = v_cnt_q;
      end
    end else begin
      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
    end
  end

  // Next state of the pin register and the sticky underflow flag
  always_comb begin
    color_d = color_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    uf_d    = uf_q;
    if (pix_en_s) begin
      hs_d    = hs_n_s;
      vs_d    = vs_n_s;
      color_d = (active_s && pix_valid) ? pix_data : BLACK;
    end else begin
      hs_d    = hs_q;
      vs_d    = vs_q;
      color_d = color_q;
    end
    // a new starve takes priority over a clear in the same cycle
    if (pix_en_s && active_s && !pix_valid) begin
      uf_d = 1'b1;
    end else if (underflow_clr) begin
      uf_d = 1'b0;
    end else begin
      uf_d = uf_q;
    end
  end

  // State register: counters, pins and underflow, async reset to raster origin
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= DIV_ZERO;
      h_cnt_q   <= 10'd0;
      v_cnt_q   <= 10'd0;
      color_q   <= BLACK;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      uf_q      <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      color_q   <= color_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      uf_q      <= uf_d;
    end
  end

  assign pix_ready   = pix_en_s && active_s;
  assign frame_start = pix_en_s && (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
  assign line_start  = pix_en_s && (h_cnt_q == 10'd0);
  assign pix_x       = h_cnt_q;
  assign pix_y       = v_cnt_q;
  assign underflow   = uf_q;
  assign vga_color   = color_q;
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized scoreboard bench for vga_timing_gen using a
// reduced raster so several frames fit in a short run.
module tb_vga_timing_gen;

  localparam int D   = 2;
  localparam int HV  = 16;
  localparam int HF  = 2;
  localparam int HSW = 4;
  localparam int HB  = 3;
  localparam int VV  = 8;
  localparam int VF  = 2;
  localparam int VSW = 2;
  localparam int VB  = 3;
  localparam int HT  = HV + HF + HSW + HB;
  localparam int VT  = VV + VF + VSW + VB;
  localparam int FRAME_CLK = D * HT * VT;
  localparam int LINE_CLK  = D * HT;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_valid;
  logic [11:0] pix_data;
  logic        pix_ready;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        frame_start;
  logic        line_start;
  logic        underflow;
  logic        underflow_clr;
  logic [11:0] vga_color;
  logic        vga_hs;
  logic        vga_vs;

  vga_timing_gen #(
    .CLK_DIV(D), .H_VIS(HV), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB), .COLOR_W(12)
  ) dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y),
    .frame_start(frame_start), .line_start(line_start),
    .underflow(underflow), .underflow_clr(underflow_clr),
    .vga_color(vga_color), .vga_hs(vga_hs), .vga_vs(vga_vs)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ready, fs, ls, hs, vs, uf;
    logic [9:0]  x, y;
    logic [11:0] color;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad   = 0;

  // reference model state: clocks elapsed since reset release plus pin image
  int          m_n = 0;
  logic [11:0] m_color = 12'h000;
  logic        m_hs = 1'b1, m_vs = 1'b1, m_uf = 1'b0;

  function automatic int px(input int nn);
    return (nn / D) % HT;
  endfunction

  function automatic int py(input int nn);
    return ((nn / D) / HT) % VT;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // apply one cycle of stimulus, push the expectation, advance the model over the edge
  task automatic drive(input logic r, input logic v, input logic [11:0] d, input logic c);
    exp_t e;
    bit   en, act;
    int   x, y;
    @(negedge clk);
    rst = r; pix_valid = v; pix_data = d; underflow_clr = c;
    if (r) begin
      m_n = 0; m_color = 12'h000; m_hs = 1'b1; m_vs = 1'b1; m_uf = 1'b0;
    end
    en  = !r && ((m_n % D) == D - 1);
    x   = px(m_n);
    y   = py(m_n);
    act = (x < HV) && (y < VV);
    e.ready = en && act;
    e.fs    = en && x == 0 && y == 0;
    e.ls    = en && x == 0;
    e.x     = 10'(x);
    e.y     = 10'(y);
    e.color = m_color;
    e.hs    = m_hs;
    e.vs    = m_vs;
    e.uf    = m_uf;
    sbq.push_back(e);
    if (!r) begin
      if (en) begin
        m_hs    = !(x >= HV + HF && x < HV + HF + HSW);
        m_vs    = !(y >= VV + VF && y < VV + VF + VSW);
        m_color = (act && v) ? d : 12'h000;
      end
      if (en && act && !v) m_uf = 1'b1;
      else if (c) m_uf = 1'b0;
      m_n++;
    end
  endtask

  // monitor: pop one expectation per cycle and compare, plus edge-spacing checks
  initial begin
    exp_t e;
    int cyc = 0, last_fs = -1, last_hf = -1, last_vf = -1;
    logic prev_hs = 1'b1, prev_vs = 1'b1;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (sbq.size() == 0) begin
        bad++; total++;
        $display("FAIL sb_empty actual=0 expected=1 t=%0t", $time);
      end else begin
        e = sbq.pop_front();
        chk("pix_ready", 32'(pix_ready), 32'(e.ready));
        chk("frame_start", 32'(frame_start), 32'(e.fs));
        chk("line_start", 32'(line_start), 32'(e.ls));
        chk("pix_x", 32'(pix_x), 32'(e.x));
        chk("pix_y", 32'(pix_y), 32'(e.y));
        chk("vga_color", 32'(vga_color), 32'(e.color));
        chk("vga_hs", 32'(vga_hs), 32'(e.hs));
        chk("vga_vs", 32'(vga_vs), 32'(e.vs));
        chk("underflow", 32'(underflow), 32'(e.uf));
      end
      if (rst) begin
        last_fs = -1; last_hf = -1; last_vf = -1;
      end else begin
        if (frame_start) begin
          if (last_fs >= 0) chk("fs_period", 32'(cyc - last_fs), 32'(FRAME_CLK));
          last_fs = cyc;
        end
        if (prev_hs && !vga_hs) begin
          if (last_hf >= 0) chk("hs_period", 32'(cyc - last_hf), 32'(LINE_CLK));
          last_hf = cyc;
        end
        if (prev_vs && !vga_vs) begin
          if (last_vf >= 0) chk("vs_period", 32'(cyc - last_vf), 32'(FRAME_CLK));
          last_vf = cyc;
        end
      end
      prev_hs = vga_hs;
      prev_vs = vga_vs;
    end
  end

  // stimulus sequence
  initial begin
    bit reached;
    bit v, c;
    int x, y;
    rst = 1'b1; pix_valid = 1'b1; pix_data = 12'h000; underflow_clr = 1'b0;

    // reset held three clocks with a valid source
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b1, 12'h000, 1'b0);

    // two frames of steady streaming
    for (int k = 0; k < 2 * FRAME_CLK; k++) drive(1'b0, 1'b1, 12'hABC, 1'b0);

    // starve (5,3); starve (7,3) with clear; clear alone during (12,3)
    for (int k = 0; k < FRAME_CLK; k++) begin
      x = px(m_n); y = py(m_n);
      v = !((x == 5 || x == 7) && y == 3);
      c = (x == 7 || x == 12) && y == 3;
      drive(1'b0, v, 12'h5A5, c);
    end

    // one frame of random traffic
    for (int k = 0; k < FRAME_CLK; k++)
      drive(1'b0, $urandom_range(0, 9) != 0, 12'($urandom), $urandom_range(0, 15) == 0);

    // random traffic up to (12,5), then a mid-frame reset
    reached = 1'b0;
    for (int k = 0; k < FRAME_CLK + 10; k++) begin
      if (px(m_n) == 12 && py(m_n) == 5) begin
        reached = 1'b1;
        break;
      end
      drive(1'b0, $urandom_range(0, 7) != 0, 12'($urandom), 1'b0);
    end
    if (!reached) begin
      bad++; total++;
      $display("FAIL reach_mid actual=0 expected=1");
    end
    for (int k = 0; k < 2; k++) drive(1'b1, 1'b1, 12'h000, 1'b0);
    for (int k = 0; k < FRAME_CLK + 60; k++)
      drive(1'b0, $urandom_range(0, 9) != 0, 12'($urandom), $urandom_range(0, 31) == 0);

    #3;
    if (sbq.size() != 0) begin
      bad++; total++;
      $display("FAIL sb_leftover actual=%0d expected=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
